// File: rtl/sysbus_arbiter.sv
// Round-robin arbiter sharing the single Sysbus master interface between N pipeline clients.
// A grant holds the bus through the request phase and, for reads, through the response burst.

module sysbus_arb_port (
  input  logic sel,
  input  logic req_ph,
  input  logic resp_ph,
  input  logic bus_reqack,
  input  logic bus_respcyc,
  input  logic cli_respack,
  output logic cli_reqack,
  output logic cli_respcyc,
  output logic respack_term
);
  assign cli_reqack   = req_ph  & sel & bus_reqack;
  assign cli_respcyc  = resp_ph & sel & bus_respcyc;
  assign respack_term = resp_ph & sel & cli_respack;
endmodule

module sysbus_arbiter #(
  parameter int NUM_PORTS      = 2,
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_PORTS-1:0]                 cli_reqcyc,
  input  logic [NUM_PORTS-1:0]                 cli_wr,
  input  logic [NUM_PORTS*BUS_DATA_WIDTH-1:0]  cli_req,
  input  logic [NUM_PORTS*BUS_TAG_WIDTH-1:0]   cli_reqtag,
  output logic [NUM_PORTS-1:0]                 cli_reqack,
  output logic [NUM_PORTS-1:0]                 cli_respcyc,
  output logic [BUS_DATA_WIDTH-1:0]            cli_resp,
  output logic [BUS_TAG_WIDTH-1:0]             cli_resptag,
  input  logic [NUM_PORTS-1:0]                 cli_respack,
  output logic                                 bus_reqcyc,
  output logic [BUS_DATA_WIDTH-1:0]            bus_req,
  output logic [BUS_TAG_WIDTH-1:0]             bus_reqtag,
  input  logic                                 bus_reqack,
  input  logic                                 bus_respcyc,
  input  logic [BUS_DATA_WIDTH-1:0]            bus_resp,
  input  logic [BUS_TAG_WIDTH-1:0]             bus_resptag,
  output logic                                 bus_respack,
  output logic [$clog2(NUM_PORTS)-1:0]         owner,
  output logic                                 err_orphan
);
  localparam int OW = $clog2(NUM_PORTS);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t                                  state;
  logic [OW-1:0]                           rr_ptr, rr_next, pick;
  logic                                    wr_latched, resp_seen, any_req;
  logic                                    req_ph, resp_ph;
  logic [OW:0]                             idx;
  logic [NUM_PORTS-1:0]                    respack_term;
  logic [NUM_PORTS-1:0][BUS_DATA_WIDTH-1:0] req_v;
  logic [NUM_PORTS-1:0][BUS_TAG_WIDTH-1:0]  tag_v;

  assign req_v = cli_req;
  assign tag_v = cli_reqtag;

  // Phase qualifiers are gated by reset so every output drops without a clock edge.
  assign req_ph  = ~reset & (state == REQ);
  assign resp_ph = ~reset & (state == RESP);

  // Scan downward so the last hit is the nearest requester at or after rr_ptr.
  always_comb begin
    pick    = '0;
    any_req = 1'b0;
    idx     = '0;
    for (int k = NUM_PORTS-1; k >= 0; k--) begin
      idx = {1'b0, rr_ptr} + (OW+1)'(k);
      if (idx >= (OW+1)'(NUM_PORTS)) idx = idx - (OW+1)'(NUM_PORTS);
      if (cli_reqcyc[idx[OW-1:0]]) begin
        pick    = idx[OW-1:0];
        any_req = 1'b1;
      end
    end
  end

  assign rr_next = (owner == OW'(NUM_PORTS-1)) ? '0 : owner + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= '0;
      rr_ptr     <= '0;
      wr_latched <= 1'b0;
      resp_seen  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (any_req) begin
          owner      <= pick;
          wr_latched <= cli_wr[pick];
          state      <= REQ;
        end
        REQ: if (!cli_reqcyc[owner]) begin
          if (wr_latched) begin
            state  <= IDLE;
            rr_ptr <= rr_next;
          end else begin
            state     <= RESP;
            resp_seen <= 1'b0;
          end
        end
        RESP: begin
          if (bus_respcyc) resp_seen <= 1'b1;
          else if (resp_seen) begin
            state  <= IDLE;
            rr_ptr <= rr_next;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    sysbus_arb_port u_port (
      .sel          (owner == OW'(i)),
      .req_ph       (req_ph),
      .resp_ph      (resp_ph),
      .bus_reqack   (bus_reqack),
      .bus_respcyc  (bus_respcyc),
      .cli_respack  (cli_respack[i]),
      .cli_reqack   (cli_reqack[i]),
      .cli_respcyc  (cli_respcyc[i]),
      .respack_term (respack_term[i])
    );
  end

  assign bus_reqcyc  = req_ph & cli_reqcyc[owner];
  assign bus_req     = req_ph ? req_v[owner] : '0;
  assign bus_reqtag  = req_ph ? tag_v[owner] : '0;
  assign bus_respack = |respack_term;
  assign cli_resp    = resp_ph ? bus_resp : '0;
  assign cli_resptag = resp_ph ? bus_resptag : '0;
  // Responses outside RESP are never routed; flag them instead.
  assign err_orphan  = ~reset & bus_respcyc & (state != RESP);

endmodule
